// File: rtl/controle_multiciclo.sv
// controle_multiciclo: Moore control FSM for the multicycle MIPS datapath.
// Sequences fetch, decode and execute, one state per clock, and stalls on
// memory through mem_pronta. Outputs are registered from the next state, so
// they always match the state the FSM is in.
// Optional feature: define CONTROLE_TRAP_OPCODE_EN to trap unsupported
// opcodes into a sticky ERRO state. Without it they execute as a NOP.
module controle_multiciclo #(
   parameter logic [5:0] OP_R    = 6'h00,
   parameter logic [5:0] OP_LW   = 6'h23,
   parameter logic [5:0] OP_SW   = 6'h2B,
   parameter logic [5:0] OP_BEQ  = 6'h04,
   parameter logic [5:0] OP_J    = 6'h02,
   parameter logic [5:0] OP_ADDI = 6'h08
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_pronta,
   output logic [1:0] selecao_pc,
   output logic       escreve_pc,
   output logic       iord,
   output logic       le_mem,
   output logic       escreve_mem,
   output logic       escreve_ir,
   output logic       mem_para_reg,
   output logic       reg_dest,
   output logic       escreve_reg,
   output logic       seleciona_a,
   output logic [1:0] seleciona_b,
   output logic [1:0] alu_op,
   output logic [3:0] estado,
   output logic       erro
);

   typedef enum logic [3:0] {
      INICIO     = 4'd0,
      BUSCA      = 4'd1,
      DECODIFICA = 4'd2,
      CALC_END   = 4'd3,
      LE_MEM     = 4'd4,
      ESCREVE_LW = 4'd5,
      ESCREVE_SW = 4'd6,
      EXEC_R     = 4'd7,
      COMPLETA_R = 4'd8,
      EXEC_I     = 4'd9,
      COMPLETA_I = 4'd10,
      DESVIO     = 4'd11,
      SALTO      = 4'd12,
      ERRO       = 4'd13
   } estado_t;

   // Per-state control word. The PC write enable is split into three
   // qualifiers (fetch, conditional branch, unconditional jump) that are
   // combined with mem_pronta / zero outside the register.
   typedef struct packed {
      logic [1:0] sel_pc;
      logic       pc_busca;
      logic       pc_cond;
      logic       pc_incond;
      logic       iord;
      logic       le;
      logic       esc_mem;
      logic       ir_busca;
      logic       m2r;
      logic       rdst;
      logic       esc_reg;
      logic       sel_a;
      logic [1:0] sel_b;
      logic [1:0] alu;
   } saida_t;

   estado_t r_estado;
   estado_t w_prox;
   saida_t  r_saida;
   logic    r_erro;

   // Next-state function; encodings 14-15 fall into default and restart at BUSCA.
   function automatic estado_t f_prox(input estado_t s, input logic [5:0] op,
                                      input logic mp);
      estado_t n;
      n = BUSCA;
      case (s)
         INICIO:     n = BUSCA;
         BUSCA:      n = mp ? DECODIFICA : BUSCA;
         DECODIFICA: begin
            if (op == OP_LW || op == OP_SW) n = CALC_END;
            else if (op == OP_R)            n = EXEC_R;
            else if (op == OP_ADDI)         n = EXEC_I;
            else if (op == OP_BEQ)          n = DESVIO;
            else if (op == OP_J)            n = SALTO;
            else begin
`ifdef CONTROLE_TRAP_OPCODE_EN
               n = ERRO;
`else
               n = BUSCA;
`endif
            end
         end
         // opcode is stable since DECODIFICA, so only LW/SW get here
         CALC_END:   n = (op == OP_LW) ? LE_MEM : ((op == OP_SW) ? ESCREVE_SW : BUSCA);
         LE_MEM:     n = mp ? ESCREVE_LW : LE_MEM;
         ESCREVE_LW: n = BUSCA;
         ESCREVE_SW: n = mp ? BUSCA : ESCREVE_SW;
         EXEC_R:     n = COMPLETA_R;
         COMPLETA_R: n = BUSCA;
         EXEC_I:     n = COMPLETA_I;
         COMPLETA_I: n = BUSCA;
         DESVIO:     n = BUSCA;
         SALTO:      n = BUSCA;
         ERRO:       n = ERRO;
         default:    n = BUSCA;
      endcase
      return n;
   endfunction

   // Control word for a state; anything not set stays 0.
   function automatic saida_t f_saida(input estado_t s);
      saida_t o;
      o = '0;
      case (s)
         BUSCA: begin
            o.le       = 1'b1;
            o.sel_b    = 2'b01;
            o.ir_busca = 1'b1;
            o.pc_busca = 1'b1;
         end
         DECODIFICA: o.sel_b = 2'b11;
         CALC_END: begin
            o.sel_a = 1'b1;
            o.sel_b = 2'b10;
         end
         LE_MEM: begin
            o.le   = 1'b1;
            o.iord = 1'b1;
         end
         ESCREVE_LW: begin
            o.esc_reg = 1'b1;
            o.m2r     = 1'b1;
         end
         ESCREVE_SW: begin
            o.esc_mem = 1'b1;
            o.iord    = 1'b1;
         end
         EXEC_R: begin
            o.sel_a = 1'b1;
            o.alu   = 2'b10;
         end
         COMPLETA_R: begin
            o.esc_reg = 1'b1;
            o.rdst    = 1'b1;
         end
         EXEC_I: begin
            o.sel_a = 1'b1;
            o.sel_b = 2'b10;
         end
         COMPLETA_I: o.esc_reg = 1'b1;
         DESVIO: begin
            o.sel_a   = 1'b1;
            o.alu     = 2'b01;
            o.sel_pc  = 2'b01;
            o.pc_cond = 1'b1;
         end
         SALTO: begin
            o.sel_pc    = 2'b10;
            o.pc_incond = 1'b1;
         end
         default: o = '0;
      endcase
      return o;
   endfunction

   assign w_prox = f_prox(r_estado, opcode, mem_pronta);

   // State and registered control word; reset clears both at once so every
   // strobe drops without waiting for a clock edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_estado <= INICIO;
         r_saida  <= '0;
         r_erro   <= 1'b0;
      end else begin
         r_estado <= w_prox;
         r_saida  <= f_saida(w_prox);
`ifdef CONTROLE_TRAP_OPCODE_EN
         r_erro   <= (w_prox == ERRO);
`else
         r_erro   <= 1'b0;
`endif
      end
   end

   assign estado       = r_estado;
   assign selecao_pc   = r_saida.sel_pc;
   assign escreve_pc   = (r_saida.pc_busca & mem_pronta) |
                         (r_saida.pc_cond & zero) |
                         r_saida.pc_incond;
   assign iord         = r_saida.iord;
   assign le_mem       = r_saida.le;
   assign escreve_mem  = r_saida.esc_mem;
   assign escreve_ir   = r_saida.ir_busca & mem_pronta;
   assign mem_para_reg = r_saida.m2r;
   assign reg_dest     = r_saida.rdst;
   assign escreve_reg  = r_saida.esc_reg;
   assign seleciona_a  = r_saida.sel_a;
   assign seleciona_b  = r_saida.sel_b;
   assign alu_op       = r_saida.alu;
   assign erro         = r_erro;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Bench for controle_multiciclo: per-cycle vector table of inputs and
// expected state; expected outputs come from a per-state table.
module tb_controle_multiciclo;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] opcode = 6'h00;
   logic       zero = 1'b0;
   logic       mem_pronta = 1'b1;
   logic [1:0] selecao_pc;
   logic       escreve_pc, iord, le_mem, escreve_mem, escreve_ir;
   logic       mem_para_reg, reg_dest, escreve_reg, seleciona_a;
   logic [1:0] seleciona_b, alu_op;
   logic [3:0] estado;
   logic       erro;

   controle_multiciclo dut (
      .clock(clock), .reset(reset), .opcode(opcode), .zero(zero),
      .mem_pronta(mem_pronta), .selecao_pc(selecao_pc), .escreve_pc(escreve_pc),
      .iord(iord), .le_mem(le_mem), .escreve_mem(escreve_mem),
      .escreve_ir(escreve_ir), .mem_para_reg(mem_para_reg), .reg_dest(reg_dest),
      .escreve_reg(escreve_reg), .seleciona_a(seleciona_a),
      .seleciona_b(seleciona_b), .alu_op(alu_op), .estado(estado), .erro(erro)
   );

   always #5 clock = ~clock;

   // {selecao_pc, escreve_pc, iord, le_mem, escreve_mem, escreve_ir,
   //  mem_para_reg, reg_dest, escreve_reg, seleciona_a, seleciona_b, alu_op, erro}
   typedef struct packed {
      logic [3:0]  st;
      logic [15:0] outs;
   } exp_t;

   typedef struct packed {
      logic       rst;
      logic [5:0] op;
      logic       z;
      logic       mp;
      logic [3:0] st;
   } vec_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   // Expected outputs for a state, straight from the state/output table.
   function automatic logic [15:0] exp_outs(input logic [3:0] st, input logic mp,
                                            input logic z);
      logic [1:0] spc, sb_, alu;
      logic epc, io, le, em, eir, m2r, rd, er, sa, err;
      {spc, epc, io, le, em, eir, m2r, rd, er, sa, sb_, alu, err} = '0;
      case (st)
         4'd1:  begin le = 1; sb_ = 2'b01; eir = mp; epc = mp; end
         4'd2:  sb_ = 2'b11;
         4'd3:  begin sa = 1; sb_ = 2'b10; end
         4'd4:  begin le = 1; io = 1; end
         4'd5:  begin er = 1; m2r = 1; end
         4'd6:  begin em = 1; io = 1; end
         4'd7:  begin sa = 1; alu = 2'b10; end
         4'd8:  begin er = 1; rd = 1; end
         4'd9:  begin sa = 1; sb_ = 2'b10; end
         4'd10: er = 1;
         4'd11: begin sa = 1; alu = 2'b01; spc = 2'b01; epc = z; end
         4'd12: begin spc = 2'b10; epc = 1; end
         4'd13: err = 1;
         default: ;
      endcase
      return {spc, epc, io, le, em, eir, m2r, rd, er, sa, sb_, alu, err};
   endfunction

   function automatic logic [15:0] act_outs();
      return {selecao_pc, escreve_pc, iord, le_mem, escreve_mem, escreve_ir,
              mem_para_reg, reg_dest, escreve_reg, seleciona_a, seleciona_b,
              alu_op, erro};
   endfunction

   task automatic add(input logic r, input logic [5:0] op, input logic z,
                      input logic mp, input logic [3:0] st);
      vec_t v;
      v.rst = r; v.op = op; v.z = z; v.mp = mp; v.st = st;
      vecs.push_back(v);
   endtask

   task automatic push_exp(input logic [3:0] st);
      exp_t e;
      e.st   = st;
      e.outs = exp_outs(st, mem_pronta, zero);
      sb.push_back(e);
   endtask

   task automatic pop_cmp(input string name);
      exp_t e;
      e = sb.pop_front();
      n_vec++;
      if (estado !== e.st || act_outs() !== e.outs) begin
         n_err++;
         $display("FAIL %s: got estado=%0d outs=%04h, want estado=%0d outs=%04h",
                  name, estado, act_outs(), e.st, e.outs);
      end
   endtask

   initial begin
      // reset and R-type
      add(1, 6'h00, 0, 1, 0);
      add(0, 6'h00, 0, 1, 0);
      add(0, 6'h00, 0, 1, 1); add(0, 6'h00, 0, 1, 2);
      add(0, 6'h00, 0, 1, 7); add(0, 6'h00, 0, 1, 8);
      // ADDI
      add(0, 6'h08, 0, 1, 1); add(0, 6'h08, 0, 1, 2);
      add(0, 6'h08, 0, 1, 9); add(0, 6'h08, 0, 1, 10);
      // LW with fetch stall and 3-cycle memory stall
      add(0, 6'h23, 0, 0, 1); add(0, 6'h23, 0, 1, 1);
      add(0, 6'h23, 0, 1, 2); add(0, 6'h23, 0, 1, 3);
      add(0, 6'h23, 0, 0, 4); add(0, 6'h23, 0, 0, 4); add(0, 6'h23, 0, 0, 4);
      add(0, 6'h23, 0, 1, 4); add(0, 6'h23, 0, 1, 5);
      // SW with one stall cycle
      add(0, 6'h2B, 0, 1, 1); add(0, 6'h2B, 0, 1, 2); add(0, 6'h2B, 0, 1, 3);
      add(0, 6'h2B, 0, 0, 6); add(0, 6'h2B, 0, 1, 6);
      // BEQ not taken, then taken
      add(0, 6'h04, 0, 1, 1); add(0, 6'h04, 0, 1, 2); add(0, 6'h04, 0, 1, 11);
      add(0, 6'h04, 1, 1, 1); add(0, 6'h04, 1, 1, 2); add(0, 6'h04, 1, 1, 11);
      // J
      add(0, 6'h02, 0, 1, 1); add(0, 6'h02, 0, 1, 2); add(0, 6'h02, 0, 1, 12);
      // unsupported opcode
      add(0, 6'h3F, 0, 1, 1); add(0, 6'h3F, 0, 1, 2);
`ifdef CONTROLE_TRAP_OPCODE_EN
      for (int i = 0; i < 10; i++) add(0, 6'h3F, i[0], i[1], 13);
`else
      add(0, 6'h3F, 0, 1, 1); add(0, 6'h3F, 0, 1, 2);
`endif
      // reset, then R-type up to EXEC_R
      add(1, 6'h00, 0, 1, 0); add(0, 6'h00, 0, 1, 0);
      add(0, 6'h00, 0, 1, 1); add(0, 6'h00, 0, 1, 2); add(0, 6'h00, 0, 1, 7);

      foreach (vecs[i]) begin
         @(negedge clock);
         reset = vecs[i].rst; opcode = vecs[i].op;
         zero = vecs[i].z; mem_pronta = vecs[i].mp;
         push_exp(vecs[i].st);
         #1 pop_cmp($sformatf("vec%0d", i));
      end

      // reset asserted in the middle of EXEC_R takes effect immediately
      #2 reset = 1'b1;
      push_exp(4'd0);
      #1 pop_cmp("mid_reset");
      @(negedge clock);
      reset = 1'b0;
      push_exp(4'd0);
      #1 pop_cmp("reset_release");
      @(negedge clock);
      push_exp(4'd1);
      #1 pop_cmp("busca_after_reset");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
